// File: rtl/coreedac_pkg.sv
// coreedac_pkg
// Shared definitions for the COREEDAC (39,32) SEC-DED code. The encoder and
// the decoder both use H_COL and calc_check, so the two always agree on the
// code. Codeword layout: data in [38:7], check bits in [6:0].
//
// H_COL holds 32 distinct weight-3 columns (Hsiao form). With odd-weight
// columns, every double error yields an even, nonzero syndrome, and every
// single data error yields a weight-3 syndrome. Single check-bit errors
// yield a weight-1 syndrome. No weight-1 or weight-3 pattern is ambiguous.
package coreedac_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 7;
    localparam int CODE_W = DATA_W + CHK_W;

    localparam logic [CHK_W-1:0] H_COL [0:DATA_W-1] = '{
        7'h07, 7'h38, 7'h43, 7'h1C, 7'h0B, 7'h13, 7'h23, 7'h0D,
        7'h15, 7'h25, 7'h45, 7'h19, 7'h29, 7'h49, 7'h31, 7'h51,
        7'h61, 7'h0E, 7'h16, 7'h26, 7'h46, 7'h1A, 7'h2A, 7'h4A,
        7'h32, 7'h52, 7'h62, 7'h2C, 7'h4C, 7'h34, 7'h54, 7'h58
    };

    // Decoded word as it leaves the classification stage.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sbe;
        logic              dbe;
    } dec_res_t;

    // Check bit j is the XOR of every data bit i whose column has bit j set.
    function automatic logic [CHK_W-1:0] calc_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        chk = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) chk = chk ^ H_COL[i];
        end
        return chk;
    endfunction

endpackage

// File: rtl/coreedac_syndrome.sv
// coreedac_syndrome
// Combinational syndrome generator: recompute check bits from the received
// data and XOR with the received check bits. A zero syndrome means no error.
// Ports:
//   data  in  DATA_W  received data bits
//   chk   in  CHK_W   received check bits
//   syn   out CHK_W   syndrome
module coreedac_syndrome
    import coreedac_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  chk,
    output logic [CHK_W-1:0]  syn
);

    assign syn = calc_check(data) ^ chk;

endmodule

// File: rtl/coreedac_dec_pipe.sv
// coreedac_dec_pipe
// Two-stage pipelined SEC-DED decoder for the COREEDAC (39,32) code.
//   Stage 1: register data and syndrome.
//   Stage 2: classify the syndrome, correct a single data-bit error, and
//            register the results into the outputs.
// The whole pipe advances together when the output register is empty or
// being drained (adv). in_ready is adv, so it depends combinationally on
// out_ready.
//
// Optional feature: define COREEDAC_ERRCNT_EN to build the saturating
// sbe/dbe counters and cnt_clr. When it is undefined, the counters read 0
// and cnt_clr is ignored.
//
// Ports:
//   CLK, RSTN          clock; synchronous active-low reset
//   in_valid/in_ready  input handshake; in_code = {data[31:0], check[6:0]}
//   out_valid/out_ready output handshake
//   out_data           corrected data (raw data when out_dbe is set)
//   out_sbe, out_dbe   single error corrected / uncorrectable error
//   cnt_clr            clear both counters
//   sbe_cnt, dbe_cnt   saturating counts of accepted sbe/dbe words
module coreedac_dec_pipe
    import coreedac_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sbe,
    output logic              out_dbe,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sbe_cnt,
    output logic [CNT_W-1:0]  dbe_cnt
);

    logic              adv;
    logic [2:1]        vld_pipe;   // [1] = stage 1, [2] = output stage
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_syn;
    logic [CHK_W-1:0]  syn;
    logic [DATA_W-1:0] flip;
    logic              syn_onehot;
    dec_res_t          res;

    assign adv       = !vld_pipe[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[2];

    coreedac_syndrome u_syn (
        .data (in_code[CODE_W-1:CHK_W]),
        .chk  (in_code[CHK_W-1:0]),
        .syn  (syn)
    );

    // Stage 1. Valid bits shift on every advance so bubbles move through too.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_syn   <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[1], in_valid};
            if (in_valid) begin
                s1_data <= in_code[CODE_W-1:CHK_W];
                s1_syn  <= syn;
            end
        end
    end

    // Classification. Columns are distinct, so at most one flip bit is set.
    // A weight-1 syndrome is a check-bit error, and the data passes through.
    // Anything else that is nonzero is uncorrectable.
    always_comb begin
        flip = '0;
        res  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            flip[i] = (s1_syn == H_COL[i]);
        end
        syn_onehot = (s1_syn != '0) && ((s1_syn & (s1_syn - CHK_W'(1))) == '0);
        res.sbe    = (|flip) || syn_onehot;
        res.dbe    = (s1_syn != '0) && !res.sbe;
        res.data   = s1_data ^ flip;
    end

    // Output stage. It holds while stalled.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            out_data <= '0;
            out_sbe  <= 1'b0;
            out_dbe  <= 1'b0;
        end else if (adv && vld_pipe[1]) begin
            out_data <= res.data;
            out_sbe  <= res.sbe;
            out_dbe  <= res.dbe;
        end
    end

`ifdef COREEDAC_ERRCNT_EN
    logic fire;
    assign fire = out_valid && out_ready;

    // A clear beats an increment in the same cycle. Both counters stick at all-ones.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else if (cnt_clr) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else if (fire) begin
            if (out_sbe && !(&sbe_cnt)) sbe_cnt <= sbe_cnt + CNT_W'(1);
            if (out_dbe && !(&dbe_cnt)) dbe_cnt <= dbe_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sbe_cnt = '0;
    assign dbe_cnt = '0;
`endif

endmodule
